// File: rtl/mem_ptr_update_unit.sv
// Pointer update unit: holds the architectural X/Y/Z/SP pointers, applies the
// post-inc / pre-dec (push/pop) side effects of accepted requests and writeback
// loads, and presents registered effective addresses to the memory stage.
// Pointer index: 0=SP 1=X 2=Y 3=Z.
module mem_ptr_update_unit #(
    parameter logic [15:0] SP_RESET    = 16'hFFFF,
    parameter logic [15:0] PTR_RESET   = 16'h0000,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_req_valid,
    input  logic [1:0]  i_req_sel,
    input  logic [1:0]  i_req_mode,
    input  logic        i_wb_en,
    input  logic [1:0]  i_wb_sel,
    input  logic [15:0] i_wb_data,
    output logic [15:0] o_x_ptr,
    output logic [15:0] o_y_ptr,
    output logic [15:0] o_z_ptr,
    output logic [15:0] o_stack_ptr,
    output logic        o_addr_valid,
    output logic        o_sp_overflow,
    output logic        o_sp_underflow
);

    localparam logic [1:0] SEL_SP   = 2'b00;
    localparam logic [1:0] MODE_INC = 2'b01;
    localparam logic [1:0] MODE_DEC = 2'b10;

    // Reset image shared by the architectural and effective register files.
    localparam logic [3:0][15:0] RST_IMG = {PTR_RESET, PTR_RESET, PTR_RESET, SP_RESET};

    logic [3:0][15:0] r_arch;
    logic [3:0][15:0] r_eff;
    logic             r_addr_valid;
    logic             r_sp_overflow;
    logic             r_sp_underflow;

    logic [3:0][15:0] w_arch_nxt;
    logic [3:0][15:0] w_eff_nxt;
    logic             w_acc;
    logic             w_inc;
    logic             w_dec;
    logic [15:0]      w_p;
    logic [15:0]      w_p_inc;
    logic [15:0]      w_p_dec;
    logic             w_sp_req;

    assign w_acc    = i_req_valid & ~i_stall;
    assign w_inc    = (i_req_mode == MODE_INC);
    assign w_dec    = (i_req_mode == MODE_DEC);
    assign w_p      = r_arch[i_req_sel];
    assign w_p_inc  = w_p + 16'd1;
    assign w_p_dec  = w_p - 16'd1;
    assign w_sp_req = w_acc & (i_req_sel == SEL_SP);

    // Next architectural and effective values; writeback overrides the
    // request side effect on the same pointer, but never the effective value.
    always_comb begin
        w_arch_nxt = r_arch;
        w_eff_nxt  = r_eff;
        if (w_acc && w_inc) w_arch_nxt[i_req_sel] = w_p_inc;
        if (w_acc && w_dec) w_arch_nxt[i_req_sel] = w_p_dec;
        if (i_wb_en)        w_arch_nxt[i_wb_sel]  = i_wb_data;
        if (!i_stall) begin
            w_eff_nxt = r_arch;
            if (w_acc) w_eff_nxt[i_req_sel] = w_dec ? w_p_dec : w_p;
        end
    end

    // Pointer register files.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_arch <= RST_IMG;
            r_eff  <= RST_IMG;
        end else begin
            r_arch <= w_arch_nxt;
            r_eff  <= w_eff_nxt;
        end
    end

    // Valid tracks the last non-stalled request slot; SP flags are sticky.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr_valid   <= 1'b0;
            r_sp_overflow  <= 1'b0;
            r_sp_underflow <= 1'b0;
        end else begin
            if (!i_stall) r_addr_valid <= i_req_valid;
            if (w_sp_req && w_dec && (r_arch[SEL_SP] == STACK_LIMIT)) r_sp_overflow  <= 1'b1;
            if (w_sp_req && w_inc && (r_arch[SEL_SP] == SP_RESET))    r_sp_underflow <= 1'b1;
        end
    end

    assign o_stack_ptr    = r_eff[0];
    assign o_x_ptr        = r_eff[1];
    assign o_y_ptr        = r_eff[2];
    assign o_z_ptr        = r_eff[3];
    assign o_addr_valid   = r_addr_valid;
    assign o_sp_overflow  = r_sp_overflow;
    assign o_sp_underflow = r_sp_underflow;

endmodule

// File: tb/tb_mem_ptr_update_unit.sv
// Bench for mem_ptr_update_unit: directed scenarios with literal expectations,
// then randomized traffic; every cycle the outputs are compared with a
// behavioural pointer model.
module tb_mem_ptr_update_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_sel = 2'b00;
    logic [1:0]  req_mode = 2'b00;
    logic        wb_en = 1'b0;
    logic [1:0]  wb_sel = 2'b00;
    logic [15:0] wb_data = 16'h0;
    logic [15:0] x_ptr, y_ptr, z_ptr, stack_ptr;
    logic        addr_valid, sp_overflow, sp_underflow;

    int n_cmp = 0;
    int n_bad = 0;

    mem_ptr_update_unit dut (
        .i_clock(clk), .i_reset(rst), .i_stall(stall),
        .i_req_valid(req_valid), .i_req_sel(req_sel), .i_req_mode(req_mode),
        .i_wb_en(wb_en), .i_wb_sel(wb_sel), .i_wb_data(wb_data),
        .o_x_ptr(x_ptr), .o_y_ptr(y_ptr), .o_z_ptr(z_ptr), .o_stack_ptr(stack_ptr),
        .o_addr_valid(addr_valid), .o_sp_overflow(sp_overflow), .o_sp_underflow(sp_underflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Pointers indexed by select code: 0=SP 1=X 2=Y 3=Z.
    logic [15:0] m_arch [4];
    logic [15:0] m_eff  [4];
    logic        m_val, m_ovf, m_unf;

    always @(posedge clk or posedge rst) begin
        logic [15:0] old [4];
        logic [15:0] p;
        if (rst) begin
            m_arch[0] = 16'hFFFF; m_eff[0] = 16'hFFFF;
            for (int i = 1; i < 4; i++) begin m_arch[i] = 16'h0; m_eff[i] = 16'h0; end
            m_val = 0; m_ovf = 0; m_unf = 0;
        end else begin
            for (int i = 0; i < 4; i++) old[i] = m_arch[i];
            if (!stall) begin
                for (int i = 0; i < 4; i++) m_eff[i] = old[i];
                m_val = req_valid;
                if (req_valid) begin
                    p = old[req_sel];
                    case (req_mode)
                        2'd1: begin
                            m_eff[req_sel] = p;
                            m_arch[req_sel] = p + 16'd1;
                            if (req_sel == 0 && p == 16'hFFFF) m_unf = 1;
                        end
                        2'd2: begin
                            m_eff[req_sel] = p - 16'd1;
                            m_arch[req_sel] = p - 16'd1;
                            if (req_sel == 0 && p == 16'hFF00) m_ovf = 1;
                        end
                        default: m_eff[req_sel] = p;
                    endcase
                end
            end
            if (wb_en) m_arch[wb_sel] = wb_data;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_sp",  stack_ptr, m_eff[0]);
        chk("m_x",   x_ptr,     m_eff[1]);
        chk("m_y",   y_ptr,     m_eff[2]);
        chk("m_z",   z_ptr,     m_eff[3]);
        chk("m_val", {15'd0, addr_valid},   {15'd0, m_val});
        chk("m_ovf", {15'd0, sp_overflow},  {15'd0, m_ovf});
        chk("m_unf", {15'd0, sp_underflow}, {15'd0, m_unf});
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic idle();
        req_valid = 0; wb_en = 0; stall = 0;
    endtask

    task automatic req(input logic [1:0] s, input logic [1:0] m);
        req_valid = 1; req_sel = s; req_mode = m;
    endtask

    task automatic wb(input logic [1:0] s, input logic [15:0] d);
        wb_en = 1; wb_sel = s; wb_data = d;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sp"}, stack_ptr, 16'hFFFF);
        chk({tag, "_x"},  x_ptr, 16'h0000);
        chk({tag, "_y"},  y_ptr, 16'h0000);
        chk({tag, "_z"},  z_ptr, 16'h0000);
        chk({tag, "_flags"}, {13'd0, addr_valid, sp_overflow, sp_underflow}, 16'h0);
    endtask

    initial begin
        // Reset held from time 0 with a request pending.
        req(2'd1, 2'd1);
        repeat (2) cyc();
        chk_reset_state("rst0");
        rst = 0; idle();
        cyc();

        // Post-inc X.
        wb(2'd1, 16'h1000); cyc(); idle();
        for (int k = 0; k < 3; k++) begin
            req(2'd1, 2'd1); cyc();
            chk("postinc_x", x_ptr, 16'h1000 + 16'(k));
            chk("postinc_v", {15'd0, addr_valid}, 16'd1);
        end
        idle(); cyc();
        chk("postinc_arch", x_ptr, 16'h1003);
        chk("idle_v", {15'd0, addr_valid}, 16'd0);

        // Push/pop.
        req(2'd0, 2'd2); cyc(); chk("push1", stack_ptr, 16'hFFFE);
        cyc();                  chk("push2", stack_ptr, 16'hFFFD);
        req(2'd0, 2'd1); cyc(); chk("pop1", stack_ptr, 16'hFFFD);
        cyc();                  chk("pop2", stack_ptr, 16'hFFFE);
        idle(); cyc();          chk("sp_arch", stack_ptr, 16'hFFFF);
        chk("no_unf", {15'd0, sp_underflow}, 16'd0);
        req(2'd0, 2'd1); cyc(); chk("pop_empty", stack_ptr, 16'hFFFF);
        chk("underflow", {15'd0, sp_underflow}, 16'd1);
        idle(); cyc(); chk("sp_wrap", stack_ptr, 16'h0000);

        // Z wrap.
        wb(2'd3, 16'hFFFF); cyc(); idle();
        req(2'd3, 2'd1); cyc(); chk("z_postinc", z_ptr, 16'hFFFF);
        idle(); cyc();          chk("z_wrap", z_ptr, 16'h0000);
        req(2'd3, 2'd2); cyc(); chk("z_predec", z_ptr, 16'hFFFF);

        // Overflow.
        idle(); wb(2'd0, 16'hFF00); cyc(); idle();
        chk("no_ovf", {15'd0, sp_overflow}, 16'd0);
        req(2'd0, 2'd2); cyc(); chk("push_lim", stack_ptr, 16'hFEFF);
        chk("overflow", {15'd0, sp_overflow}, 16'd1);

        // Stall: Y is 0, valid set by a plain Y request first.
        req(2'd2, 2'd0); cyc(); chk("y_plain", y_ptr, 16'h0000);
        stall = 1; req(2'd2, 2'd2);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("stall_y", y_ptr, 16'h0000);
            chk("stall_v", {15'd0, addr_valid}, 16'd1);
        end
        stall = 0; cyc(); chk("unstall_y", y_ptr, 16'hFFFF);

        // Collision.
        idle(); wb(2'd1, 16'h2000); cyc(); idle();
        req(2'd1, 2'd1); wb(2'd1, 16'h3000); cyc(); idle();
        chk("coll_eff", x_ptr, 16'h2000);
        req(2'd1, 2'd0); cyc(); chk("coll_arch", x_ptr, 16'h3000);

        // Mid-cycle reset with a request pending.
        req(2'd0, 2'd2); #1 rst = 1; #1;
        chk_reset_state("rst_mid");
        cyc(); cyc();
        chk_reset_state("rst_hold");
        rst = 0; idle(); cyc();

        // Randomized traffic; the per-cycle compare does the checking.
        for (int n = 0; n < 3000; n++) begin
            stall     = ($urandom_range(0, 3) == 0);
            req_valid = ($urandom_range(0, 2) != 0);
            req_sel   = 2'($urandom_range(0, 3));
            req_mode  = 2'($urandom_range(0, 3));
            wb_en     = ($urandom_range(0, 5) == 0);
            wb_sel    = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: wb_data = 16'hFF00;
                1: wb_data = 16'hFFFF;
                2: wb_data = 16'hFF01;
                default: wb_data = 16'($urandom);
            endcase
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1; #2 rst = 0;
            end
            cyc();
        end
        idle(); cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
